// File: rtl/gin_pkg.sv
// GIN multicast controller shared definitions.
// Tag-match helper and broadcast tag constant.
package gin_pkg;

  localparam int TAG_MAX = 32;
  localparam logic [TAG_MAX-1:0] BCAST_TAG = '1;

  // Tags are zero-extended to TAG_MAX; tw is the live width.
  // Bits above tw are masked off so extension cannot cause a miss.
  function automatic logic tag_match(
    input logic [TAG_MAX-1:0] tag,
    input logic [TAG_MAX-1:0] id,
    input logic [TAG_MAX-1:0] mask,
    input logic               bcast_en,
    input int unsigned        tw
  );
    logic [TAG_MAX-1:0] ones;
    logic hit;
    logic bc;
    ones = BCAST_TAG >> (TAG_MAX - tw);
    hit  = (((tag ^ id) & mask & ones) == '0);
    bc   = bcast_en && (tag == ones);
    return hit | bc;
  endfunction

endpackage

// File: rtl/gin_sync_fifo.sv
// Synchronous FIFO with occupancy count.
// Ports: clk, reset, push/wr_data, pop/rd_data, full, empty, count.
module gin_sync_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic do_push;
  logic do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gin_mcc_buffered.sv
// Buffered GIN multicast controller: scan-configured id/mask tag
// filter feeding a FIFO toward one destination.
// Ports: link_clk, reset; data_in/tag/enable_in/ready_out (bus side);
// data_out/enable_out/ready_in (destination side);
// se_id/si_id/so_id (config scan chain); occupancy (FIFO count).
module gin_mcc_buffered
  import gin_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 4,
  parameter int FIFO_DEPTH = 2,
  parameter bit BCAST_EN   = 1'b1
) (
  input  logic                            link_clk,
  input  logic                            reset,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic [TAG_WIDTH-1:0]            tag,
  input  logic                            enable_in,
  output logic                            ready_out,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            enable_out,
  input  logic                            ready_in,
  input  logic                            se_id,
  input  logic                            si_id,
  output logic                            so_id,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] occupancy
);

  localparam int CFG_W = 2 * TAG_WIDTH;

  logic [CFG_W-1:0]      cfg;
  logic [TAG_WIDTH-1:0]  id;
  logic [TAG_WIDTH-1:0]  mask;
  logic                  match;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] head;

  assign id    = cfg[CFG_W-1:TAG_WIDTH];
  assign mask  = cfg[TAG_WIDTH-1:0];
  assign so_id = cfg[CFG_W-1];

  // Reset state is id=0 with an exact-match mask.
  always_ff @(posedge link_clk) begin
    if (reset) begin
      cfg <= {{TAG_WIDTH{1'b0}}, {TAG_WIDTH{1'b1}}};
    end else if (se_id) begin
      cfg <= {cfg[CFG_W-2:0], si_id};
    end
  end

  assign match = tag_match(
    TAG_MAX'(tag), TAG_MAX'(id), TAG_MAX'(mask),
    BCAST_EN, unsigned'(TAG_WIDTH));

  // Non-matching packets are always sunk so the bus can complete.
  // full is registered state, so ready_in never reaches ready_out.
  assign ready_out = ~se_id & (~match | ~full);
  assign push      = enable_in & ready_out & match;
  assign enable_out = ~empty;
  assign pop       = enable_out & ready_in;
  assign data_out  = empty ? '0 : head;

  gin_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (link_clk),
    .reset   (reset),
    .push    (push),
    .wr_data (data_in),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (occupancy)
  );

endmodule

// File: tb/tb_gin_mcc_buffered.sv
// Bench for gin_mcc_buffered: directed vectors, queue scoreboard.
// Two instances: broadcast enabled and broadcast disabled.
module tb_gin_mcc_buffered;

  logic        link_clk = 1'b0;
  logic        reset;
  logic [63:0] data_in;
  logic [3:0]  tag;
  logic        enable_in;
  logic        ready_in;
  logic        se_id;
  logic        si_id;

  logic        ready_out, enable_out, so_id;
  logic [63:0] data_out;
  logic [1:0]  occupancy;
  logic        ready_out0, enable_out0, so_id0;
  logic [63:0] data_out0;
  logic [1:0]  occupancy0;

  int errors = 0;
  int checks = 0;
  logic [63:0] q1 [$];
  logic [63:0] q0 [$];
  logic [63:0] e1, e0;

  always #5 link_clk = ~link_clk;

  gin_mcc_buffered #(
    .DATA_WIDTH(64), .TAG_WIDTH(4),
    .FIFO_DEPTH(2), .BCAST_EN(1'b1)
  ) dut (
    .link_clk(link_clk), .reset(reset),
    .data_in(data_in), .tag(tag),
    .enable_in(enable_in), .ready_out(ready_out),
    .data_out(data_out), .enable_out(enable_out),
    .ready_in(ready_in), .se_id(se_id),
    .si_id(si_id), .so_id(so_id),
    .occupancy(occupancy)
  );

  gin_mcc_buffered #(
    .DATA_WIDTH(64), .TAG_WIDTH(4),
    .FIFO_DEPTH(2), .BCAST_EN(1'b0)
  ) dut0 (
    .link_clk(link_clk), .reset(reset),
    .data_in(data_in), .tag(tag),
    .enable_in(enable_in), .ready_out(ready_out0),
    .data_out(data_out0), .enable_out(enable_out0),
    .ready_in(ready_in), .se_id(se_id),
    .si_id(si_id), .so_id(so_id0),
    .occupancy(occupancy0)
  );

  // Monitors: a pop happens at the next posedge, compare now.
  always @(negedge link_clk) begin
    if (!reset && enable_out && ready_in) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL mon_bcast: got %0h expected no output",
                 data_out);
      end else begin
        e1 = q1.pop_front();
        if (data_out !== e1) begin
          errors++;
          $display("FAIL mon_bcast: got %0h expected %0h",
                   data_out, e1);
        end
      end
    end
  end

  always @(negedge link_clk) begin
    if (!reset && enable_out0 && ready_in) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL mon_nobcast: got %0h expected no output",
                 data_out0);
      end else begin
        e0 = q0.pop_front();
        if (data_out0 !== e0) begin
          errors++;
          $display("FAIL mon_nobcast: got %0h expected %0h",
                   data_out0, e0);
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge link_clk);
      #1;
    end
  endtask

  // Present one packet until accepted (bounded).
  task automatic send(input logic [3:0] t,
                      input logic [63:0] d,
                      input bit m1, input bit m0,
                      input bit must_ready);
    int n;
    n = 0;
    tag = t;
    data_in = d;
    enable_in = 1'b1;
    @(negedge link_clk);
    if (must_ready) chk("ready_now", 64'(ready_out), 64'd1);
    while (!ready_out && n < 20) begin
      @(negedge link_clk);
      n++;
    end
    if (!ready_out) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready_out=0 expected 1");
    end else begin
      if (m1) q1.push_back(d);
      if (m0 && ready_out0) q0.push_back(d);
    end
    @(posedge link_clk);
    #1;
    enable_in = 1'b0;
  endtask

  // Shift val in MSB first; so_id must replay prev.
  task automatic scan(input logic [7:0] val,
                      input logic [7:0] prev);
    se_id = 1'b1;
    for (int i = 0; i < 8; i++) begin
      si_id = val[7-i];
      @(negedge link_clk);
      chk("so_id", 64'(so_id), 64'(prev[7-i]));
      chk("so_id_nb", 64'(so_id0), 64'(prev[7-i]));
      if (i == 0) chk("scan_ready", 64'(ready_out), 64'd0);
      @(posedge link_clk);
      #1;
    end
    se_id = 1'b0;
    si_id = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    data_in = '0;
    tag = '0;
    enable_in = 1'b0;
    ready_in = 1'b0;
    se_id = 1'b0;
    si_id = 1'b0;
    idle(2);
    reset = 1'b0;

    @(negedge link_clk);
    chk("rst_enable_out", 64'(enable_out), 64'd0);
    chk("rst_data_out", data_out, 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_occ_nb", 64'(occupancy0), 64'd0);
    chk("rst_so_id", 64'(so_id), 64'd0);
    chk("rst_ready_out", 64'(ready_out), 64'd1);
    @(posedge link_clk);
    #1;

    // id=5, mask=F
    scan(8'h5F, 8'h0F);
    @(negedge link_clk);
    chk("so_id_after", 64'(so_id), 64'd0);
    @(posedge link_clk);
    #1;

    ready_in = 1'b1;
    send(4'h5, 64'hA5, 1, 1, 1);
    @(negedge link_clk);
    chk("lat_enable_out", 64'(enable_out), 64'd1);
    chk("lat_data_out", data_out, 64'hA5);
    @(posedge link_clk);
    #1;
    send(4'h6, 64'h66, 0, 0, 1);
    idle(3);

    // id=4, mask=C
    scan(8'h4C, 8'h5F);
    send(4'h4, 64'hB4, 1, 1, 1);
    send(4'h7, 64'hB7, 1, 1, 1);
    send(4'h8, 64'hB8, 0, 0, 1);
    send(4'hF, 64'hBF, 1, 0, 1);
    idle(3);

    // Backpressure
    ready_in = 1'b0;
    send(4'h4, 64'hD1, 1, 1, 1);
    send(4'h5, 64'hD2, 1, 1, 1);
    @(negedge link_clk);
    chk("bp_occupancy", 64'(occupancy), 64'd2);
    @(posedge link_clk);
    #1;
    tag = 4'h6;
    data_in = 64'hD3;
    enable_in = 1'b1;
    repeat (2) begin
      @(negedge link_clk);
      chk("bp_full_ready", 64'(ready_out), 64'd0);
      @(posedge link_clk);
      #1;
    end
    tag = 4'h8;
    data_in = 64'hDD;
    @(negedge link_clk);
    chk("bp_nomatch_ready", 64'(ready_out), 64'd1);
    @(posedge link_clk);
    #1;
    enable_in = 1'b0;
    ready_in = 1'b1;
    send(4'h6, 64'hD3, 1, 1, 0);
    idle(4);

    // Simultaneous push/pop at occupancy 1
    ready_in = 1'b0;
    send(4'h4, 64'hE1, 1, 1, 1);
    ready_in = 1'b1;
    tag = 4'h7;
    data_in = 64'hE2;
    enable_in = 1'b1;
    @(negedge link_clk);
    chk("pp_occ_before", 64'(occupancy), 64'd1);
    chk("pp_ready", 64'(ready_out), 64'd1);
    q1.push_back(64'hE2);
    q0.push_back(64'hE2);
    @(posedge link_clk);
    #1;
    enable_in = 1'b0;
    ready_in = 1'b0;
    @(negedge link_clk);
    chk("pp_occ_after", 64'(occupancy), 64'd1);
    chk("pp_head", data_out, 64'hE2);
    @(posedge link_clk);
    #1;

    // Config interlock while draining
    send(4'h5, 64'hF1, 1, 1, 1);
    se_id = 1'b1;
    si_id = 1'b0;
    ready_in = 1'b1;
    tag = 4'h4;
    data_in = 64'hF2;
    enable_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge link_clk);
      chk("se_ready", 64'(ready_out), 64'd0);
      chk("se_drain_occ", 64'(occupancy), 64'(2 - i));
      @(posedge link_clk);
      #1;
    end
    se_id = 1'b0;
    enable_in = 1'b0;

    // cfg 4C shifted left by three zeros -> 60
    scan(8'h4C, 8'h60);
    ready_in = 1'b0;
    send(4'h4, 64'h61, 1, 1, 1);
    send(4'h6, 64'h62, 1, 1, 1);
    @(negedge link_clk);
    chk("pre_rst_occ", 64'(occupancy), 64'd2);
    @(posedge link_clk);
    #1;
    reset = 1'b1;
    q1.delete();
    q0.delete();
    @(posedge link_clk);
    #1;
    reset = 1'b0;
    @(negedge link_clk);
    chk("mid_rst_enable", 64'(enable_out), 64'd0);
    chk("mid_rst_data", data_out, 64'd0);
    chk("mid_rst_occ", 64'(occupancy), 64'd0);
    chk("mid_rst_ready", 64'(ready_out), 64'd1);
    @(posedge link_clk);
    #1;

    // Back to id=0, exact mask
    ready_in = 1'b1;
    send(4'h0, 64'h70, 1, 1, 1);
    send(4'h3, 64'h73, 0, 0, 1);
    send(4'h4, 64'h74, 0, 0, 1);
    idle(3);
    scan(8'h00, 8'h0F);
    idle(4);

    chk("q_bcast_empty", 64'(q1.size()), 64'd0);
    chk("q_nobcast_empty", 64'(q0.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
